// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: opcode bit indices, default sizes,
// result-flag bit positions and the skid-buffer state encoding.
package alu_pkg;

  localparam int ALU_WIDTH   = 16;
  localparam int ALU_NUM_OPS = 12;

  localparam int OP_AND     = 0;
  localparam int OP_OR      = 1;
  localparam int OP_NOT     = 2;
  localparam int OP_XOR     = 3;
  localparam int OP_NAND    = 4;
  localparam int OP_NOR     = 5;
  localparam int OP_XNOR    = 6;
  localparam int OP_ADD     = 7;
  localparam int OP_SUB     = 8;
  localparam int OP_SHRIGHT = 9;
  localparam int OP_SHLEFT  = 10;
  localparam int OP_CLEAR   = 11;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ILL  = 2;
  localparam int NUM_FLAGS = 3;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. Handshake outputs decode the
// state register only, so neither side sees a combinational path.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_t   state, state_nxt;
  logic [DW-1:0] head, skid;
  logic          push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SKID_EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      SKID_EMPTY: if (push) state_nxt = SKID_ONE;
      SKID_ONE: begin
        if (push && !pop)      state_nxt = SKID_FULL;
        else if (!push && pop) state_nxt = SKID_EMPTY;
      end
      SKID_FULL:  if (pop) state_nxt = SKID_ONE;
      default:    state_nxt = SKID_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != SKID_FULL);
    out_valid = (state != SKID_EMPTY);
  end

  // NOTE: the payload registers are reset too, because out_data and
  // out_flags must read zero after reset, not just be "don't care".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else if (state == SKID_FULL) begin
      if (pop) head <= skid;
    end else if (push) begin
      // Head is refilled when it is free or leaving; otherwise park in skid.
      if (state == SKID_EMPTY || pop) head <= in_data;
      else                            skid <= in_data;
    end
  end

  assign out_data = head;

endmodule

// File: rtl/alu_result_sel.sv
// Registered one-hot result selector with zero/negative/illegal flags.
// Optional ALU_SEL_ERRCNT_EN builds a saturating illegal-select counter.
module alu_result_sel
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int NUM_OPS = ALU_NUM_OPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS-1:0]       in_sel,
  input  logic [NUM_OPS*WIDTH-1:0] in_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [NUM_FLAGS-1:0]     out_flags,
  output logic [7:0]               err_count
);

  localparam int PW = WIDTH + NUM_FLAGS;

  logic                 sel_onehot;
  logic                 sel_ill;
  logic [WIDTH-1:0]     sel_data;
  logic [NUM_FLAGS-1:0] sel_flags;
  logic [PW-1:0]        out_payload;

  assign sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - NUM_OPS'(1))) == '0);

  // OP_CLEAR is a legal select that deliberately yields zero.
  always_comb begin
    sel_data = '0;
    sel_ill  = !sel_onehot;
    if (sel_onehot) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (in_sel[k] && k != OP_CLEAR) sel_data = sel_data | in_res[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    sel_flags            = '0;
    sel_flags[FLAG_ZERO] = (sel_data == '0);
    sel_flags[FLAG_NEG]  = sel_data[WIDTH-1];
    sel_flags[FLAG_ILL]  = sel_ill;
  end

  alu_skid_buf #(.DW(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel_flags, sel_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_data  = out_payload[WIDTH-1:0];
  assign out_flags = out_payload[PW-1:WIDTH];

`ifdef ALU_SEL_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (in_valid && in_ready && sel_ill && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/alu_result_sel.md
# alu_result_sel

Registered, parametrised result selector for the 16-bit ALU datapath. Accepts one beat of all functional-unit results plus a one-hot opcode over a valid/ready handshake. Emits the selected result with zero/negative/illegal-select flags one cycle later. Holds full throughput under downstream backpressure via a 2-entry skid buffer. It sits between the functional units (logic, add/sub, shifters) and the register write-back.

## Interface
Parameters:
- WIDTH, 16, bit width of every result word
- NUM_OPS, 12, number of one-hot opcode bits and result channels

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_sel  input  NUM_OPS  one-hot opcode
- in_res  input  NUM_OPS*WIDTH  flattened results; channel k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  WIDTH  selected result
- out_flags  output  3  {illegal, negative, zero}
- err_count  output  8  saturating count of illegal selects (see Configuration)

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Selection:
  - in_sel exactly one bit k set and k != OP_CLEAR: data = channel k.
  - k == OP_CLEAR: data = 0, illegal = 0.
  - in_sel == 0 or more than one bit set: data = 0, illegal = 1.
- Channel contents (add/sub share one channel, etc.) are the upstream's concern; every bit index maps to its own channel.
- Flags are computed from the selected data:
  - zero = (data == 0)
  - negative = data[WIDTH-1]
  - illegal per the rules above
- Beats are never reordered, dropped or duplicated.
- Skid buffer states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1, holds 2 beats.
  - Transitions: push-only goes +1, pop-only goes -1, simultaneous push+pop holds state.
- In FULL, in_ready is low, so a push cannot occur. A pop moves the state to ONE and raises in_ready the next cycle.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented at out_data from edge N onward (registered). Output signals never combinationally depend on in_*.
- in_ready is a registered signal derived from the buffer state only. It never depends combinationally on out_ready.
- Throughput is 1 beat/cycle while out_ready=1.
- out_data and out_flags remain stable while out_valid=1 && out_ready=0.
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - out_valid=0, out_data=0, out_flags=0, err_count=0
  - buffer state EMPTY, in_ready=1
- Reset asserted mid-transfer discards all buffered beats.
- err_count increments on the edge that accepts an illegal beat and saturates at 255.

## Configuration
- ALU_SEL_ERRCNT_EN defined: err_count is a live saturating counter, as described above.
- ALU_SEL_ERRCNT_EN undefined: no counter logic is built and err_count is tied to 0. The illegal flag in out_flags is still produced.

## Structure
Shared package alu_pkg holds:
- opcode bit-index constants: OP_AND=0, OP_OR=1, OP_NOT=2, OP_XOR=3, OP_NAND=4, OP_NOR=5, OP_XNOR=6, OP_ADD=7, OP_SUB=8, OP_SHRIGHT=9, OP_SHLEFT=10, OP_CLEAR=11
- the NUM_OPS default
- flag bit positions: FLAG_ZERO=0, FLAG_NEG=1, FLAG_ILL=2

Sub-module alu_skid_buf:
- generic 2-entry valid/ready buffer with payload width WIDTH+3
- the selection/flag logic stays in the top

## Test plan
- Reset then single beat: in_sel=1<<OP_ADD, ADD channel=16'h1234. Response: out_valid=1 on the next cycle, out_data=16'h1234, flags=3'b000.
- Negative and zero flags:
  - OP_SUB channel=16'h8000 gives flags=3'b010.
  - OP_AND channel=0 gives flags=3'b001.
- Illegal selects: in_sel=0, then in_sel=12'b000000000011. Each gives out_data=0 and flags=3'b101; err_count=2 with macro defined, 0 without.
- Backpressure: stream 5 beats (OP_OR with values 1..5) with out_ready held low for 3 cycles. Response: in_ready drops after 2 accepted beats, and all 5 values emerge in order with no loss.
- Full-rate stream: 100 beats with random legal one-hot opcodes and out_ready=1. Response: 1 output per cycle matching the reference selection; in_ready is never low.
- Reset mid-operation: assert rst_n=0 while FULL. Response: out_valid=0 and in_ready=1 immediately (asynchronous), err_count=0, and no stale beat appears after release.
